// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: shared constants, FSM state type and the psum -> ofmap
// arithmetic used by psum_drain.
//   PSUM_W  signed psum width arriving from the bottom PE
//   OUT_W   signed ofmap width delivered to the writer
//   SUM_W   one guard bit so psum + bias can never wrap
package psum_drain_pkg;

  localparam int PSUM_W = 10;
  localparam int OUT_W  = 8;
  localparam int SUM_W  = PSUM_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // bias add, optional ReLU, arithmetic (floor) right shift, saturate to OUT_W
  function automatic logic [OUT_W-1:0] sat_shift(
    input logic [PSUM_W-1:0] psum,
    input logic [PSUM_W-1:0] bias,
    input logic              relu_en,
    input int                shift
  );
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    logic [SUM_W-OUT_W:0]    upper;
    sum = $signed({psum[PSUM_W-1], psum}) + $signed({bias[PSUM_W-1], bias});
    if (relu_en && sum[SUM_W-1]) begin
      sum = '0;
    end
    shifted = sum >>> shift;
    // the value fits when every bit above the OUT_W sign bit copies it
    upper = shifted[SUM_W-1:OUT_W-1];
    if ((&upper) || !(|upper)) begin
      return shifted[OUT_W-1:0];
    end else if (shifted[SUM_W-1]) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/psum_drain_if.sv
// psum_drain_if: ofmap output port of psum_drain towards the ofmap writer.
//   ofmap_o        head result data
//   ofmap_valid_o  a result is presented
//   ofmap_ready_i  writer can take the result
//   ofmap_last_o   presented result is the final one of the frame
// Handshake: a transfer happens on every rising edge where ofmap_valid_o and
// ofmap_ready_i are both high. Once valid is high the data/last stay stable
// until that transfer; ready may be raised or dropped freely and never
// influences valid.
interface psum_drain_if;
  import psum_drain_pkg::*;

  logic [OUT_W-1:0] ofmap_o;
  logic             ofmap_valid_o;
  logic             ofmap_ready_i;
  logic             ofmap_last_o;

  modport master (
    output ofmap_o,
    output ofmap_valid_o,
    output ofmap_last_o,
    input  ofmap_ready_i
  );

  modport slave (
    input  ofmap_o,
    input  ofmap_valid_o,
    input  ofmap_last_o,
    output ofmap_ready_i
  );
endinterface

// File: rtl/psum_drain_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a separate occupancy count.
//   clk_i, rst_i  clock, synchronous active-high reset (flushes contents)
//   push_i        write wdata_i (taken when not full, or full with a pop)
//   pop_i         drop the head entry (ignored when empty)
//   rdata_o       head entry; when empty, the last entry popped (0 after reset)
//   empty_o/full_o/count_o  occupancy
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  // when empty, keep showing the last word handed out rather than stale RAM
  assign rdata_o = empty_o ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end
endmodule

// File: rtl/psum_drain.sv
// psum_drain: output stage below one systolic-array column.
// Takes the unstallable psum stream, applies bias/ReLU/shift/saturation in one
// registered stage and queues results in a FIFO behind a valid/ready port.
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           begin a frame, latching num/bias/relu (IDLE only)
//   num_outputs_i     results in the frame (0 means 1)
//   bias_i, relu_en_i per-frame arithmetic config
//   psum_i/psum_valid_i  psum stream, no backpressure
//   ofmap             result port (psum_drain_if master)
//   busy_o            frame in progress
//   done_o            one-cycle pulse once the frame has fully left
//   overflow_o        sticky: a result was dropped on a full FIFO
//   dbg_state_o       current FSM state
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int SHIFT = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_outputs_i,
  input  logic [PSUM_W-1:0] bias_i,
  input  logic              relu_en_i,
  input  logic [PSUM_W-1:0] psum_i,
  input  logic              psum_valid_i,
  psum_drain_if.master      ofmap,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output state_e            dbg_state_o
);
  localparam int FW     = OUT_W + 1;
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PSUM_W-1:0]   bias_q, bias_d;
  logic                relu_q, relu_d;
  logic                ovf_q, ovf_d;
  logic                stage_valid_q, stage_valid_d;
  logic [OUT_W-1:0]    stage_data_q, stage_data_d;
  logic                stage_last_q, stage_last_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic [FW-1:0]       fifo_rdata;
  logic                fifo_empty;
  logic                fifo_full;
  logic [FCNT_W-1:0]   fifo_count;

  assign fifo_pop  = ofmap.ofmap_ready_i && !fifo_empty;
  assign fifo_push = stage_valid_q && (!fifo_full || fifo_pop);

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    count_d       = count_q;
    bias_d        = bias_q;
    relu_d        = relu_q;
    ovf_d         = ovf_q;
    stage_valid_d = 1'b0;
    stage_data_d  = stage_data_q;
    stage_last_d  = stage_last_q;

    if (stage_valid_q && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          num_d   = (num_outputs_i == '0) ? CNT_W'(1) : num_outputs_i;
          bias_d  = bias_i;
          relu_d  = relu_en_i;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (psum_valid_i && (count_q < num_q)) begin
          stage_valid_d = 1'b1;
          stage_data_d  = sat_shift(psum_i, bias_q, relu_q, SHIFT);
          stage_last_d  = (count_q == num_q - CNT_W'(1));
          count_d       = count_q + CNT_W'(1);
          if (count_d == num_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // finished once nothing is left in the stage and the FIFO is empty
        // after this edge; also covers a final result that was dropped
        if (!stage_valid_q &&
            (fifo_empty || ((fifo_count == FCNT_W'(1)) && fifo_pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      num_q         <= '0;
      count_q       <= '0;
      bias_q        <= '0;
      relu_q        <= 1'b0;
      ovf_q         <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      count_q       <= count_d;
      bias_q        <= bias_d;
      relu_q        <= relu_d;
      ovf_q         <= ovf_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      stage_last_q  <= stage_last_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({stage_last_q, stage_data_q}),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign ofmap.ofmap_o       = fifo_rdata[OUT_W-1:0];
  assign ofmap.ofmap_valid_o = !fifo_empty;
  assign ofmap.ofmap_last_o  = fifo_rdata[OUT_W] && !fifo_empty;
  assign busy_o              = (state_q != IDLE);
  assign done_o              = (state_q == DONE);
  assign overflow_o          = ovf_q;
  assign dbg_state_o         = state_q;
endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;
  import psum_drain_pkg::*;

  localparam int CNT_W = 16;
  localparam int DEPTH = 8;
  localparam int SHIFT = 2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_outputs = '0;
  logic [PSUM_W-1:0] bias = '0;
  logic              relu_en = 1'b0;
  logic [PSUM_W-1:0] psum = '0;
  logic              psum_valid = 1'b0;
  logic              busy;
  logic              done;
  logic              overflow;
  state_e            dbg_state;

  psum_drain_if bus();

  psum_drain #(.SHIFT(SHIFT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .num_outputs_i (num_outputs),
    .bias_i        (bias),
    .relu_en_i     (relu_en),
    .psum_i        (psum),
    .psum_valid_i  (psum_valid),
    .ofmap         (bus),
    .busy_o        (busy),
    .done_o        (done),
    .overflow_o    (overflow),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Results expected at the ofmap port, oldest first: {last, data}
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] got_q[$];
  int   done_cnt = 0;

  int   m_phase = 0;   // 0 idle, 1 frame active, 2 done pulse
  int   m_num = 0;
  int   m_acc = 0;
  int   m_bias = 0;
  bit   m_relu = 1'b0;
  bit   m_ovf = 1'b0;
  bit   pipe_v = 1'b0;
  logic [OUT_W:0] pipe_item = '0;

  function automatic logic [OUT_W-1:0] model_out(input int p, input int b, input bit relu);
    int s;
    int div;
    div = 1 << SHIFT;
    s = p + b;
    if (relu && s < 0) s = 0;
    s = (s >= 0) ? s / div : -((-s + div - 1) / div);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return OUT_W'(s);
  endfunction

  task automatic model_step();
    int ph_old;
    int p;
    bit pop;
    if (rst) begin
      exp_q.delete();
      m_phase = 0; m_acc = 0; m_ovf = 1'b0; pipe_v = 1'b0;
      return;
    end
    ph_old = m_phase;
    pop = (exp_q.size() > 0) && bus.ofmap_ready_i;
    if (pop) void'(exp_q.pop_front());
    if (pipe_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pipe_item);
      else m_ovf = 1'b1;
    end
    pipe_v = 1'b0;
    case (ph_old)
      0: if (start) begin
        m_num = (num_outputs == 0) ? 1 : int'(num_outputs);
        m_bias = $signed(bias);
        m_relu = relu_en;
        m_acc = 0;
        m_ovf = 1'b0;
        m_phase = 1;
      end
      1: begin
        if (psum_valid && m_acc < m_num) begin
          p = $signed(psum);
          pipe_item = {(m_acc == m_num - 1), model_out(p, m_bias, m_relu)};
          pipe_v = 1'b1;
          m_acc++;
        end
        // frame over when every accepted result has left (popped or dropped)
        if (m_acc == m_num && !pipe_v && exp_q.size() == 0) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare + handshake monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("valid", bus.ofmap_valid_o, exp_q.size() > 0);
      if (exp_q.size() > 0) check("data", bus.ofmap_o, exp_q[0][OUT_W-1:0]);
      check("last", bus.ofmap_last_o, (exp_q.size() > 0) ? exp_q[0][OUT_W] : 1'b0);
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == 2);
      check("overflow", overflow, m_ovf);
    end
    if (bus.ofmap_valid_o && bus.ofmap_ready_i) got_q.push_back({bus.ofmap_last_o, bus.ofmap_o});
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n, input int b, input bit r);
    num_outputs = CNT_W'(n);
    bias = PSUM_W'(b);
    relu_en = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int p);
    psum = PSUM_W'(p);
    psum_valid = 1'b1;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check({name, " finish"}, busy, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  int exp_vals[10];
  int d0;

  initial begin
    bus.ofmap_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // model pins: hand-computed results
    check("model 100", model_out(100, 0, 1'b0), 8'd25);
    check("model relu", model_out(-40, 0, 1'b1), 8'h00);
    check("model neg", model_out(-40, 0, 1'b0), 8'hF6);
    check("model satp", model_out(511, 511, 1'b0), 8'h7F);
    check("model satn", model_out(-512, -512, 1'b0), 8'h80);

    // reset state
    @(negedge clk);
    check("rst valid", bus.ofmap_valid_o, 1'b0);
    check("rst data", bus.ofmap_o, 8'h00);
    check("rst last", bus.ofmap_last_o, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst ovf", overflow, 1'b0);
    check("rst state", dbg_state, IDLE);
    tick();

    // NUM=1, psum 100 -> 25, 2-cycle latency, done after handshake
    got_q.delete(); d0 = done_cnt;
    bus.ofmap_ready_i = 1'b1;
    start_frame(1, 0, 1'b0);
    send(100);
    @(negedge clk);
    check("lat1 valid", bus.ofmap_valid_o, 1'b0);
    @(negedge clk);
    check("lat2 valid", bus.ofmap_valid_o, 1'b1);
    check("lat2 data", bus.ofmap_o, 8'd25);
    check("lat2 last", bus.ofmap_last_o, 1'b1);
    #1;
    wait_idle("s1", 20);
    check("s1 count", got_q.size(), 1);
    if (got_q.size() >= 1) check("s1 item", got_q[0], {1'b1, 8'd25});
    check("s1 done", done_cnt - d0, 1);

    // ReLU / sign / saturation, one frame each
    got_q.delete();
    start_frame(1, 0, 1'b1);     send(-40);   wait_idle("relu1", 20);
    start_frame(1, 0, 1'b0);     send(-40);   wait_idle("relu0", 20);
    start_frame(1, 511, 1'b0);   send(511);   wait_idle("satp", 20);
    start_frame(1, -512, 1'b0);  send(-512);  wait_idle("satn", 20);
    check("arith count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("relu on", got_q[0], {1'b1, 8'h00});
      check("relu off", got_q[1], {1'b1, 8'hF6});
      check("sat pos", got_q[2], {1'b1, 8'h7F});
      check("sat neg", got_q[3], {1'b1, 8'h80});
    end

    // NUM=0 behaves as 1; extra psum ignored
    got_q.delete();
    start_frame(0, 0, 1'b0);
    send(8); send(40);
    wait_idle("num0", 20);
    check("num0 count", got_q.size(), 1);
    if (got_q.size() >= 1) check("num0 item", got_q[0], {1'b1, 8'd2});

    // overflow: NUM=9, ready low, 9 psums -> 8 stored, last dropped
    got_q.delete(); d0 = done_cnt;
    bus.ofmap_ready_i = 1'b0;
    start_frame(9, 0, 1'b0);
    for (int i = 1; i <= 9; i++) send(4 * i);
    tick(); tick(); tick();
    check("ovf flag", overflow, 1'b1);
    check("ovf valid", bus.ofmap_valid_o, 1'b1);
    bus.ofmap_ready_i = 1'b1;
    wait_idle("ovf", 40);
    check("ovf count", got_q.size(), 8);
    for (int i = 0; i < got_q.size() && i < 8; i++) check("ovf item", got_q[i], {1'b0, 8'(i + 1)});
    check("ovf done", done_cnt - d0, 1);

    // NUM=4, ready toggling 1010, back-to-back psums
    got_q.delete();
    start_frame(4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.ofmap_ready_i = (i % 2 == 0);
      send(4 * (i + 1));
    end
    for (int n = 0; n < 40 && busy; n++) begin
      bus.ofmap_ready_i = ~bus.ofmap_ready_i;
      tick();
    end
    check("tog finish", busy, 1'b0);
    check("tog count", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) check("tog item", got_q[i], {(i == 3), 8'(i + 1)});

    // fill FIFO, then push+pop while full: no loss
    got_q.delete();
    exp_vals = '{-5, -3, -1, 1, 3, 5, 7, 9, 11, 13};
    bus.ofmap_ready_i = 1'b0;
    start_frame(10, 0, 1'b0);
    for (int i = 0; i < 8; i++) send(-20 + 8 * i);
    tick(); tick();
    send(-20 + 8 * 8);
    bus.ofmap_ready_i = 1'b1;
    send(-20 + 8 * 9);
    wait_idle("full", 40);
    check("full ovf", overflow, 1'b0);
    check("full count", got_q.size(), 10);
    for (int i = 0; i < got_q.size() && i < 10; i++) check("full item", got_q[i], {(i == 9), 8'(exp_vals[i])});

    // reset mid-RUN with 3 queued, then a clean frame
    got_q.delete();
    bus.ofmap_ready_i = 1'b0;
    start_frame(8, 0, 1'b0);
    send(4); send(8); send(12);
    tick(); tick();
    check("pre-rst valid", bus.ofmap_valid_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post-rst valid", bus.ofmap_valid_o, 1'b0);
    check("post-rst busy", busy, 1'b0);
    #1;
    bus.ofmap_ready_i = 1'b1;
    start_frame(2, 4, 1'b0);
    send(8); send(16);
    wait_idle("after rst", 20);
    check("after rst count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("after rst item0", got_q[0], {1'b0, 8'd3});
      check("after rst item1", got_q[1], {1'b1, 8'd5});
    end

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
